// File: rtl/animation_sequencer.sv
// Top-level game/animation sequencer: start screen, map, coins, per-frame sprite draw/erase,
// frame delay, pause and game-over, driving one shared draw engine over a req/done handshake.
module animation_sequencer #(
  parameter int N_SPRITES    = 2,
  parameter int FRAME_CYCLES = 1048576,
  parameter int MAP_W        = 2,
  parameter int START_SCR    = 2,
  parameter int GG_SCR       = 3,
  localparam int IDX_W       = $clog2(N_SPRITES) + 1,
  localparam int CNT_W       = $clog2(FRAME_CYCLES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 button1,
  input  logic                 button2,
  input  logic                 pause_btn,
  input  logic [MAP_W-1:0]     map_sel,
  input  logic                 won,
  input  logic                 times_up,
  input  logic [N_SPRITES-1:0] coin_hit,
  input  logic                 draw_done,
  output logic                 draw_req,
  output logic [2:0]           draw_op,
  output logic [IDX_W-1:0]     draw_idx,
  output logic [MAP_W-1:0]     screen_sel,
  output logic                 ld_xy,
  output logic                 frame_tick,
  output logic                 paused,
  output logic [3:0]           state
);

  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S_WAITP  = 4'd1,
    S_WAITR  = 4'd2,
    S_MAP    = 4'd3,
    S_COINS  = 4'd4,
    S_SDRAW  = 4'd5,
    S_FRAME  = 4'd6,
    S_PAUSE  = 4'd7,
    S_SERASE = 4'd8,
    S_CERASE = 4'd9,
    S_GG     = 4'd10,
    S_GGWAIT = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    OP_SCREEN = 3'd0,
    OP_COINS  = 3'd1,
    OP_SDRAW  = 3'd2,
    OP_SERASE = 3'd3,
    OP_CERASE = 3'd4
  } op_t;

  localparam int                HIT_W     = 2 ** IDX_W;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_SPRITES - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [MAP_W-1:0]  START_VAL = MAP_W'(START_SCR);
  localparam logic [MAP_W-1:0]  GG_VAL    = MAP_W'(GG_SCR);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MAP_W-1:0] map_q, map_d;
  logic             req_q, req_d;
  logic             ld_q, ld_d;
  logic             tick_q, tick_d;
  logic             btn_armed_q, btn_armed_d;
  logic             btn_seen_q, btn_seen_d;
  logic             pause_seen_q, pause_seen_d;

  op_t              cur_op;
  logic             is_draw;
  logic             any_btn, go_gg, req_rise, op_done;
  logic [HIT_W-1:0] hit_ext;

  assign any_btn = button1 | button2;
  assign hit_ext = HIT_W'(coin_hit);
  // Game-over is decided on SDRAW entry, before the first sprite request of the frame.
  assign go_gg    = (state_q == S_SDRAW) && !req_q && (idx_q == '0) && (won | times_up);
  assign req_rise = is_draw && !req_q && !draw_done && !go_gg;
  assign op_done  = req_q && draw_done;

  // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    cur_op     = OP_SCREEN;
    screen_sel = map_q;
    is_draw    = 1'b1;
    unique case (state_q)
      S_START:          screen_sel = START_VAL;
      S_WAITP, S_WAITR: begin screen_sel = START_VAL; is_draw = 1'b0; end
      S_MAP:            cur_op = OP_SCREEN;
      S_COINS:          cur_op = OP_COINS;
      S_SDRAW:          cur_op = OP_SDRAW;
      S_FRAME, S_PAUSE: is_draw = 1'b0;
      S_SERASE:         cur_op = OP_SERASE;
      S_CERASE:         cur_op = OP_CERASE;
      S_GG:             screen_sel = GG_VAL;
      S_GGWAIT:         begin screen_sel = GG_VAL; is_draw = 1'b0; end
      default:          begin screen_sel = START_VAL; is_draw = 1'b0; end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    map_d        = map_q;
    req_d        = req_q;
    ld_d         = req_rise && (state_q == S_SDRAW);
    tick_d       = 1'b0;
    btn_armed_d  = 1'b0;
    btn_seen_d   = 1'b0;
    pause_seen_d = pause_seen_q;

    if (req_rise) req_d = 1'b1;
    if (op_done)  req_d = 1'b0;

    unique case (state_q)
      S_START: if (op_done) state_d = S_WAITP;
      S_WAITP: begin
        // A button held since the start screen must be released before it counts.
        btn_armed_d = btn_armed_q | ~any_btn;
        if (btn_armed_q && any_btn) state_d = S_WAITR;
      end
      S_WAITR: if (!any_btn) begin
        map_d   = map_sel;
        state_d = S_MAP;
      end
      S_MAP:   if (op_done) state_d = S_COINS;
      S_COINS: if (op_done) begin
        state_d = S_SDRAW;
        idx_d   = '0;
      end
      S_SDRAW: begin
        if (go_gg) begin
          state_d = S_GG;
        end else if (op_done) begin
          if (idx_q == LAST_IDX) begin
            state_d      = S_FRAME;
            idx_d        = '0;
            cnt_d        = '0;
            pause_seen_d = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_FRAME: begin
        if (cnt_q == LAST_CNT) begin
          tick_d       = 1'b1;
          state_d      = S_SERASE;
          idx_d        = '0;
          pause_seen_d = 1'b0;
        end else if (pause_seen_q && !pause_btn) begin
          state_d      = S_PAUSE;
          pause_seen_d = 1'b0;
        end else begin
          cnt_d        = cnt_q + 1'b1;
          pause_seen_d = pause_seen_q | pause_btn;
        end
      end
      S_PAUSE: begin
        if (pause_seen_q && !pause_btn) begin
          state_d      = S_FRAME;
          pause_seen_d = 1'b0;
        end else begin
          pause_seen_d = pause_seen_q | pause_btn;
        end
      end
      S_SERASE: if (op_done) begin
        if (hit_ext[idx_q]) begin
          state_d = S_CERASE;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_SDRAW;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_CERASE: if (op_done) begin
        if (idx_q == LAST_IDX) begin
          state_d = S_SDRAW;
          idx_d   = '0;
        end else begin
          state_d = S_SERASE;
          idx_d   = idx_q + 1'b1;
        end
      end
      S_GG: if (op_done) state_d = S_GGWAIT;
      S_GGWAIT: begin
        btn_armed_d = btn_armed_q | ~any_btn;
        btn_seen_d  = btn_seen_q | (btn_armed_q & any_btn);
        if (btn_seen_q && !any_btn) state_d = S_START;
      end
      default: state_d = S_START;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_START;
      idx_q        <= '0;
      cnt_q        <= '0;
      map_q        <= '0;
      req_q        <= 1'b0;
      ld_q         <= 1'b0;
      tick_q       <= 1'b0;
      btn_armed_q  <= 1'b0;
      btn_seen_q   <= 1'b0;
      pause_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      map_q        <= map_d;
      req_q        <= req_d;
      ld_q         <= ld_d;
      tick_q       <= tick_d;
      btn_armed_q  <= btn_armed_d;
      btn_seen_q   <= btn_seen_d;
      pause_seen_q <= pause_seen_d;
    end
  end

  assign draw_req   = req_q;
  assign draw_op    = cur_op;
  assign draw_idx   = idx_q;
  assign ld_xy      = ld_q;
  assign frame_tick = tick_q;
  assign paused     = (state_q == S_PAUSE);
  assign state      = state_q;

endmodule

// File: tb/tb_animation_sequencer.sv
// Randomised bench for animation_sequencer: a draw-engine responder with random latency, and a
// queue of expected draw operations built from the game rules for each scenario step.
module tb_animation_sequencer;

  localparam int         N         = 2;
  localparam int         FC        = 8;
  localparam logic [1:0] START_SCR = 2'd2;
  localparam logic [1:0] GG_SCR    = 2'd3;
  localparam logic [2:0] OP_SCREEN = 3'd0;
  localparam logic [2:0] OP_COINS  = 3'd1;
  localparam logic [2:0] OP_SDRAW  = 3'd2;
  localparam logic [2:0] OP_SERASE = 3'd3;
  localparam logic [2:0] OP_CERASE = 3'd4;

  logic       clk = 1'b0;
  logic       reset, button1, button2, pause_btn, won, times_up, draw_done;
  logic [1:0] map_sel, coin_hit;
  logic       draw_req, ld_xy, frame_tick, paused;
  logic [2:0] draw_op;
  logic [1:0] draw_idx, screen_sel;
  logic [3:0] state;

  animation_sequencer #(
    .N_SPRITES(N), .FRAME_CYCLES(FC), .MAP_W(2), .START_SCR(2), .GG_SCR(3)
  ) dut (
    .clk(clk), .reset(reset), .button1(button1), .button2(button2), .pause_btn(pause_btn),
    .map_sel(map_sel), .won(won), .times_up(times_up), .coin_hit(coin_hit),
    .draw_done(draw_done), .draw_req(draw_req), .draw_op(draw_op), .draw_idx(draw_idx),
    .screen_sel(screen_sel), .ld_xy(ld_xy), .frame_tick(frame_tick), .paused(paused),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] idx;
    logic [1:0] scr;
  } op_rec_t;

  op_rec_t exp_q[$];
  op_rec_t cur_exp, last_exp;
  int checks = 0, errors = 0;
  int cyc = 0, frame_starts = 0, ops_seen = 0, ld_pulses = 0, exp_sdraw = 0, ticks = 0;
  int expect_tick = -1, pause_rise = 0;
  int lat = 0, wait_cnt = 0, drop_lat = 0, drop_cnt = 0;
  logic prev_req = 1'b0, prev_paused = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [2:0] op, input logic [1:0] idx, input logic [1:0] scr);
    op_rec_t r;
    r.op = op; r.idx = idx; r.scr = scr;
    if (op == OP_SDRAW) exp_sdraw++;
    exp_q.push_back(r);
  endtask

  // Erase pass of one frame: each sprite erased, then its coin if that sprite collected one.
  task automatic push_erase(input logic [1:0] hits, input logic [1:0] scr);
    for (int i = 0; i < N; i++) begin
      push(OP_SERASE, 2'(i), scr);
      if (hits[i]) push(OP_CERASE, 2'(i), scr);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || draw_req || draw_done) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frame_starts < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("frame_start_reached", frame_starts >= target, 1);
  endtask

  task automatic press_release(input logic which);
    @(negedge clk);
    if (which) button2 = 1'b1; else button1 = 1'b1;
    repeat (3) @(negedge clk);
    button1 = 1'b0;
    button2 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Draw-engine responder and operation monitor, sampled 1 time unit after each rising edge.
  initial begin
    draw_done = 1'b0;
    last_exp  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
        draw_done   = 1'b0;
        prev_req    = 1'b0;
        prev_paused = 1'b0;
      end else begin
        if (draw_req && !prev_req) begin
          ops_seen++;
          check("req_gap_done_low", draw_done, 0);
          check("op_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            cur_exp = exp_q.pop_front();
            check("op_code", draw_op, cur_exp.op);
            check("op_screen", screen_sel, cur_exp.scr);
            if (cur_exp.op >= OP_SDRAW) check("op_idx", draw_idx, cur_exp.idx);
            check("ld_xy_on_req", ld_xy, cur_exp.op == OP_SDRAW);
            last_exp = cur_exp;
          end
          lat      = $urandom_range(0, 3);
          wait_cnt = 0;
          drop_lat = $urandom_range(0, 2);
          drop_cnt = 0;
        end
        if (!draw_req && prev_req) begin
          check("req_held_until_done", draw_done, 1);
          if (last_exp.op == OP_SDRAW && last_exp.idx == 2'(N - 1)) begin
            frame_starts++;
            expect_tick = cyc + FC;
          end
        end
        if (ld_xy) ld_pulses++;
        if (paused && !prev_paused) pause_rise = cyc;
        // A pause freezes the frame count for its length plus the cycle that entered it.
        if (!paused && prev_paused) expect_tick += cyc - pause_rise + 1;
        if (frame_tick) begin
          ticks++;
          check("frame_tick_time", cyc, expect_tick);
        end
        if (draw_req && !draw_done) begin
          if (wait_cnt >= lat) draw_done = 1'b1; else wait_cnt++;
        end else if (!draw_req && draw_done) begin
          if (drop_cnt >= drop_lat) draw_done = 1'b0; else drop_cnt++;
        end
        prev_req    = draw_req;
        prev_paused = paused;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0] map, map2, hits;
    int nframes, gg_sel, n;
    reset = 1'b1; button1 = 1'b1; button2 = 1'b0; pause_btn = 1'b0;
    won = 1'b0; times_up = 1'b0; map_sel = 2'd0; coin_hit = 2'd0;
    repeat (2) @(negedge clk);
    check("rst_draw_req", draw_req, 0);
    check("rst_draw_op", draw_op, OP_SCREEN);
    check("rst_draw_idx", draw_idx, 0);
    check("rst_screen_sel", screen_sel, START_SCR);
    check("rst_ld_xy", ld_xy, 0);
    check("rst_frame_tick", frame_tick, 0);
    check("rst_paused", paused, 0);
    check("rst_state", state, 0);

    // Start screen with button1 held throughout: no advance until released and pressed again.
    push(OP_SCREEN, 2'd0, START_SCR);
    reset = 1'b0;
    wait_idle("start_screen_done");
    repeat (10) @(negedge clk);
    check("held_button_no_advance", ops_seen, 1);
    button1 = 1'b0;
    repeat (5) @(negedge clk);
    check("release_only_no_advance", ops_seen, 1);

    map = 2'($urandom_range(0, 3));
    map_sel = map;
    push(OP_SCREEN, 2'd0, map);
    push(OP_COINS,  2'd0, map);
    push(OP_SDRAW,  2'd0, map);
    push(OP_SDRAW,  2'd1, map);
    press_release(1'($urandom_range(0, 1)));
    map_sel = ~map;

    nframes = $urandom_range(3, 5);
    for (int f = 0; f < nframes; f++) begin
      wait_frames(f + 1);
      hits = (f == 0) ? 2'b10 : 2'($urandom_range(0, 3));
      coin_hit = hits;
      push_erase(hits, map);
      push(OP_SDRAW, 2'd0, map);
      push(OP_SDRAW, 2'd1, map);
      if (f == 1) begin
        @(negedge clk);
        pause_btn = 1'b1;
        repeat (2) @(negedge clk);
        pause_btn = 1'b0;
        repeat (20) @(negedge clk);
        check("paused_high", paused, 1);
        pause_btn = 1'b1;
        repeat (2) @(negedge clk);
        pause_btn = 1'b0;
        repeat (3) @(negedge clk);
        check("paused_low_after_resume", paused, 0);
      end
    end

    // Game end raised mid-frame: erase completes, then game-over screen instead of sprite draw.
    wait_frames(nframes + 1);
    hits = 2'($urandom_range(0, 3));
    coin_hit = hits;
    push_erase(hits, map);
    push(OP_SCREEN, 2'd0, GG_SCR);
    gg_sel = $urandom_range(0, 2);
    won      = (gg_sel != 1);
    times_up = (gg_sel != 0);
    wait_idle("game_over_done");
    check("ld_xy_pulse_count", ld_pulses, exp_sdraw);
    check("frame_tick_count", ticks, nframes + 1);
    check("paused_low_in_gg", paused, 0);
    won = 1'b0;
    times_up = 1'b0;

    push(OP_SCREEN, 2'd0, START_SCR);
    press_release(1'($urandom_range(0, 1)));
    wait_idle("restart_screen_done");

    // Reset while the map screen request is outstanding.
    map2 = 2'($urandom_range(0, 3));
    map_sel = map2;
    push(OP_SCREEN, 2'd0, map2);
    press_release(1'($urandom_range(0, 1)));
    n = 0;
    while (!draw_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("map_req_raised", draw_req, 1);
    check("map_op_seen", exp_q.size(), 0);
    reset = 1'b1;
    #1;
    check("midop_rst_req", draw_req, 0);
    check("midop_rst_state", state, 0);
    check("midop_rst_screen", screen_sel, START_SCR);
    @(posedge clk);
    #2;
    check("midop_rst_req_edge", draw_req, 0);
    check("midop_rst_screen_edge", screen_sel, START_SCR);
    exp_q.delete();
    repeat (2) @(negedge clk);
    push(OP_SCREEN, 2'd0, START_SCR);
    reset = 1'b0;
    wait_idle("post_reset_start_screen");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
